mux_demux_rx: RTL and testbench

Sequential 2-channel demultiplexer, the receive end of the 2:1 select path. It accepts a time-multiplexed stream of W-bit words tagged with a select bit: sel=0 is channel a and sel=1 is channel b, matching the mux `s` convention. Words must arrive as a-then-b pairs. Each complete {a, b} pair is re-assembled and presented on a valid/ready output port. Out-of-order select tags are detected and counted, and the block resynchronises after each one.

---
 rtl/mux_pkg.sv | 14 +
 rtl/sat_counter.sv | 25 ++
 rtl/mux_demux_rx.sv | 160 ++++++++++++++++
 tb/tb_mux_demux_rx.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Purpose : shared types and constants for the 2-channel select path.
// Contents: demux_state_t (receive FSM encoding), SEL_A / SEL_B channel tags.
package mux_pkg;

   typedef enum logic [1:0] {
      WAIT_A,
      WAIT_B,
      FULL
   } demux_state_t;

   localparam logic SEL_A = 1'b0;
   localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// Purpose : up-counter that sticks at all-ones instead of wrapping.
// Ports   : clk, rst_n (async active-low), inc (count enable), count (registered value).
module sat_counter #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] r_count;

   // Hold once every bit is set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (inc && (r_count != {CNT_W{1'b1}})) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign count = r_count;

endmodule

// File: rtl/mux_demux_rx.sv
// Purpose : receive end of the 2:1 select path. Re-assembles a-then-b tagged
//           words into {a, b} pairs on a valid/ready port, flags and counts
//           out-of-order tags and resynchronises after each one.
// Ports   : clk, rst_n (async active-low)
//           in_valid/in_ready/in_sel/in_data  - tagged word input (sel 0 = a, 1 = b)
//           pair_valid/pair_ready/pair_a/pair_b - re-assembled pair output
//           seq_err    - one-cycle pulse per out-of-order accepted word
//           pair_count - pairs delivered (wraps); err_count - errors (saturates)
module mux_demux_rx
   import mux_pkg::*;
#(
   parameter int unsigned W     = 4,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_sel,
   input  logic [W-1:0]     in_data,
   output logic             pair_valid,
   input  logic             pair_ready,
   output logic [W-1:0]     pair_a,
   output logic [W-1:0]     pair_b,
   output logic             seq_err,
   output logic [CNT_W-1:0] pair_count,
   output logic [CNT_W-1:0] err_count
);

   demux_state_t     r_state;
   demux_state_t     w_state_nxt;
   logic             r_in_ready;
   logic             r_pair_valid;
   logic [W-1:0]     r_a;
   logic [W-1:0]     r_b;
   logic             r_seq_err;
   logic [CNT_W-1:0] r_pair_count;

   logic             w_acc;
   logic             w_take;
   logic             w_load_a;
   logic             w_load_b;
   logic             w_err;

   assign w_acc  = in_valid & r_in_ready;
   assign w_take = r_pair_valid & pair_ready;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= WAIT_A;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         WAIT_A: begin
            if (w_acc && (in_sel == SEL_A)) begin
               w_state_nxt = WAIT_B;
            end
         end
         WAIT_B: begin
            if (w_acc && (in_sel == SEL_B)) begin
               w_state_nxt = FULL;
            end
         end
         FULL: begin
            if (w_take) begin
               w_state_nxt = WAIT_A;
            end
         end
         default: w_state_nxt = WAIT_A;
      endcase
   end

   // Datapath controls decoded from state and the current accept
   always_comb begin
      w_load_a = 1'b0;
      w_load_b = 1'b0;
      w_err    = 1'b0;
      case (r_state)
         WAIT_A: begin
            if (w_acc) begin
               w_load_a = (in_sel == SEL_A);
               w_err    = (in_sel == SEL_B);
            end
         end
         WAIT_B: begin
            // A repeated a word replaces the held one: newest a wins.
            if (w_acc) begin
               w_load_a = (in_sel == SEL_A);
               w_load_b = (in_sel == SEL_B);
               w_err    = (in_sel == SEL_A);
            end
         end
         default: begin
            w_load_a = 1'b0;
         end
      endcase
   end

   // Handshake flags registered from the next state so they track r_state
   // exactly, with no combinational path from pair_ready to in_ready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_in_ready   <= 1'b1;
         r_pair_valid <= 1'b0;
         r_seq_err    <= 1'b0;
      end else begin
         r_in_ready   <= (w_state_nxt != FULL);
         r_pair_valid <= (w_state_nxt == FULL);
         r_seq_err    <= w_err;
      end
   end

   // Pair holding registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a <= '0;
         r_b <= '0;
      end else begin
         if (w_load_a) begin
            r_a <= in_data;
         end
         if (w_load_b) begin
            r_b <= in_data;
         end
      end
   end

   // Delivered-pair counter, wraps
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pair_count <= '0;
      end else if (w_take) begin
         r_pair_count <= r_pair_count + CNT_W'(1);
      end
   end

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_err_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (w_err),
      .count (err_count)
   );

   assign in_ready   = r_in_ready;
   assign pair_valid = r_pair_valid;
   assign pair_a     = r_a;
   assign pair_b     = r_b;
   assign seq_err    = r_seq_err;
   assign pair_count = r_pair_count;

endmodule

// File: tb/tb_mux_demux_rx.sv
// Purpose : self-checking bench for mux_demux_rx. A pair-level reference model
//           (pending a word, full flag, counters) is checked every cycle;
//           a vector table and directed sequences cover the corner cases,
//           followed by randomized traffic.
module tb_mux_demux_rx;

   localparam int unsigned W     = 4;
   localparam int unsigned CNT_W = 8;

   logic             clk        = 1'b0;
   logic             rst_n      = 1'b1;
   logic             in_valid   = 1'b0;
   logic             in_sel     = 1'b0;
   logic [W-1:0]     in_data    = '0;
   logic             pair_ready = 1'b0;
   logic             in_ready;
   logic             pair_valid;
   logic [W-1:0]     pair_a;
   logic [W-1:0]     pair_b;
   logic             seq_err;
   logic [CNT_W-1:0] pair_count;
   logic [CNT_W-1:0] err_count;

   always #5 clk = ~clk;

   mux_demux_rx #(
      .W     (W),
      .CNT_W (CNT_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_sel     (in_sel),
      .in_data    (in_data),
      .pair_valid (pair_valid),
      .pair_ready (pair_ready),
      .pair_a     (pair_a),
      .pair_b     (pair_b),
      .seq_err    (seq_err),
      .pair_count (pair_count),
      .err_count  (err_count)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: what has been accepted, not how the FSM encodes it.
   bit               m_have_a;
   bit               m_full;
   bit               m_err;
   logic [W-1:0]     m_a;
   logic [W-1:0]     m_b;
   int               m_pairs;
   int               m_errs;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_have_a = 0;
      m_full   = 0;
      m_err    = 0;
      m_a      = '0;
      m_b      = '0;
      m_pairs  = 0;
      m_errs   = 0;
   endtask

   task automatic model_edge(input logic v, input logic s, input logic [W-1:0] d, input logic r);
      bit acc;
      bit take;
      acc   = v && !m_full;
      take  = m_full && r;
      m_err = 0;
      if (take) begin
         m_full  = 0;
         m_pairs = m_pairs + 1;
      end else if (acc) begin
         if (s == 1'b0) begin
            if (m_have_a) m_err = 1;
            m_a      = d;
            m_have_a = 1;
         end else if (m_have_a) begin
            m_b      = d;
            m_full   = 1;
            m_have_a = 0;
         end else begin
            m_err = 1;
         end
      end
      if (m_err && m_errs < 255) m_errs = m_errs + 1;
   endtask

   task automatic compare_model();
      chk("in_ready",   32'(in_ready),   32'(!m_full));
      chk("pair_valid", 32'(pair_valid), 32'(m_full));
      chk("pair_a",     32'(pair_a),     32'(m_a));
      chk("pair_b",     32'(pair_b),     32'(m_b));
      chk("seq_err",    32'(seq_err),    32'(m_err));
      chk("pair_count", 32'(pair_count), 32'(m_pairs % 256));
      chk("err_count",  32'(err_count),  32'(m_errs));
   endtask

   // Called at a falling edge: drive, let one rising edge pass, check at the next falling edge.
   task automatic step(input logic v, input logic s, input logic [W-1:0] d, input logic r);
      in_valid   = v;
      in_sel     = s;
      in_data    = d;
      pair_ready = r;
      @(posedge clk);
      model_edge(v, s, d, r);
      @(negedge clk);
      compare_model();
   endtask

   // Asynchronous reset: outputs must clear before any clock edge.
   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("rst_in_ready",   32'(in_ready),   32'd1);
      chk("rst_pair_valid", 32'(pair_valid), 32'd0);
      chk("rst_pair_a",     32'(pair_a),     32'd0);
      chk("rst_pair_b",     32'(pair_b),     32'd0);
      chk("rst_seq_err",    32'(seq_err),    32'd0);
      chk("rst_pair_count", 32'(pair_count), 32'd0);
      chk("rst_err_count",  32'(err_count),  32'd0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic         v;
      logic         s;
      logic [3:0]   d;
      logic         r;
      logic         rdy;
      logic         vld;
      logic [3:0]   a;
      logic [3:0]   b;
      logic         err;
      logic [7:0]   pc;
      logic [7:0]   ec;
   } vec_t;

   vec_t tbl[10];

   initial begin
      //          v  s  d     r   rdy vld a     b     err pc     ec
      tbl[0] = '{1, 0, 4'h3, 1,  1,  0,  4'h3, 4'h0, 0,  8'd0, 8'd0};
      tbl[1] = '{1, 1, 4'hA, 1,  0,  1,  4'h3, 4'hA, 0,  8'd0, 8'd0};
      tbl[2] = '{1, 0, 4'h5, 1,  1,  0,  4'h3, 4'hA, 0,  8'd1, 8'd0};
      tbl[3] = '{1, 1, 4'h7, 0,  1,  0,  4'h3, 4'hA, 1,  8'd1, 8'd1};
      tbl[4] = '{0, 0, 4'hF, 0,  1,  0,  4'h3, 4'hA, 0,  8'd1, 8'd1};
      tbl[5] = '{1, 0, 4'h1, 0,  1,  0,  4'h1, 4'hA, 0,  8'd1, 8'd1};
      tbl[6] = '{1, 0, 4'h9, 0,  1,  0,  4'h9, 4'hA, 1,  8'd1, 8'd2};
      tbl[7] = '{1, 1, 4'hE, 0,  0,  1,  4'h9, 4'hE, 0,  8'd1, 8'd2};
      tbl[8] = '{1, 0, 4'h4, 0,  0,  1,  4'h9, 4'hE, 0,  8'd1, 8'd2};
      tbl[9] = '{1, 1, 4'h2, 1,  1,  0,  4'h9, 4'hE, 0,  8'd2, 8'd2};

      #2;
      do_reset();

      // Vector table from reset
      for (int i = 0; i < 10; i++) begin
         step(tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].r);
         chk($sformatf("tbl%0d_rdy", i), 32'(in_ready),   32'(tbl[i].rdy));
         chk($sformatf("tbl%0d_vld", i), 32'(pair_valid), 32'(tbl[i].vld));
         chk($sformatf("tbl%0d_a", i),   32'(pair_a),     32'(tbl[i].a));
         chk($sformatf("tbl%0d_b", i),   32'(pair_b),     32'(tbl[i].b));
         chk($sformatf("tbl%0d_err", i), 32'(seq_err),    32'(tbl[i].err));
         chk($sformatf("tbl%0d_pc", i),  32'(pair_count), 32'(tbl[i].pc));
         chk($sformatf("tbl%0d_ec", i),  32'(err_count),  32'(tbl[i].ec));
      end

      // Backpressure: pair 5/C held for 4 stalled cycles with in_valid driven
      step(1, 0, 4'h5, 0);
      step(1, 1, 4'hC, 0);
      for (int i = 0; i < 4; i++) begin
         step(1, 0, W'(i + 1), 0);
         chk("bp_in_ready",   32'(in_ready),   32'd0);
         chk("bp_pair_valid", 32'(pair_valid), 32'd1);
         chk("bp_pair_a",     32'(pair_a),     32'h5);
         chk("bp_pair_b",     32'(pair_b),     32'hC);
      end
      step(1, 0, 4'h8, 1);
      chk("bp_release_ready", 32'(in_ready),   32'd1);
      chk("bp_release_valid", 32'(pair_valid), 32'd0);
      chk("bp_release_pc",    32'(pair_count), 32'd3);

      // 256 clean pairs from reset: count passes 255 then wraps to 0
      do_reset();
      for (int i = 0; i < 256; i++) begin
         step(1, 0, W'(i), 0);
         step(1, 1, W'(i + 7), 0);
         step(0, 0, '0, 1);
         if (i == 254) chk("pc_255", 32'(pair_count), 32'd255);
      end
      chk("pc_wrap", 32'(pair_count), 32'd0);
      chk("pc_wrap_ec", 32'(err_count), 32'd0);

      // 300 order errors in WAIT_A: count saturates, pulse keeps firing
      for (int i = 0; i < 300; i++) begin
         step(1, 1, W'(i), 0);
      end
      chk("ec_sat",       32'(err_count),  32'hFF);
      chk("ec_sat_pulse", 32'(seq_err),    32'd1);
      chk("ec_sat_valid", 32'(pair_valid), 32'd0);

      // Reset while holding a partial pair, then a lone b word is an error
      step(1, 0, 4'h6, 0);
      chk("mid_a", 32'(pair_a), 32'h6);
      do_reset();
      step(1, 1, 4'hF, 0);
      chk("mid_b_err",   32'(seq_err),    32'd1);
      chk("mid_b_valid", 32'(pair_valid), 32'd0);
      chk("mid_b_ec",    32'(err_count),  32'd1);
      chk("mid_b_pb",    32'(pair_b),     32'd0);

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 3) != 0), 1'($urandom), W'($urandom), ($urandom_range(0, 2) != 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
